vga_sprite_ctrl: RTL and testbench

- Parametrised VGA timing generator with a single rectangular sprite overlay, fetched from an external synchronous ROM.
- Successor to the fixed 640x480 centred-image controller. Adds parametrised timing and sprite size, a run-time sprite position with a per-frame latch, configurable ROM latency compensation, a data-enable output and a frame-start pulse.
- Sits between the pixel-clock PLL output and the RGB565 VGA DAC pins.

---
 rtl/vga_sprite_ctrl.sv | 154 +++++++++++++++
 tb/tb_vga_sprite_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_ctrl.sv
// VGA timing generator with one rectangular sprite overlay read from a synchronous ROM.
// Optional colour-keyed transparency is enabled by defining VGA_SPRITE_TRANSPARENT_EN.
module vga_sprite_ctrl #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          SYNC_POL  = 0,
  parameter int          SPR_W     = 48,
  parameter int          SPR_H     = 48,
  parameter int          ROM_LAT   = 1,
  parameter int          ADDR_W    = 12,
  parameter int          CNT_W     = 11,
  parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  spr_x,
  input  logic [CNT_W-1:0]  spr_y,
  input  logic [15:0]       bg_color,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_q,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [4:0]        vga_r,
  output logic [5:0]        vga_g,
  output logic [4:0]        vga_b,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int SPR_N   = SPR_W * SPR_H;
  localparam logic SYNC_ACT = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0] PX_MAX = CNT_W'(H_ACTIVE - SPR_W);
  localparam logic [CNT_W-1:0] PY_MAX = CNT_W'(V_ACTIVE - SPR_H);

  typedef struct packed {
    logic hs;
    logic vs;
    logic vld;
    logic spr;
    logic fs;
  } ctl_t;

  function automatic logic [CNT_W-1:0] clamp_pos(input logic [CNT_W-1:0] pos,
                                                 input logic [CNT_W-1:0] lim);
    return (pos > lim) ? lim : pos;
  endfunction

  function automatic logic [15:0] pix_sel(input ctl_t c, input logic [15:0] q,
                                          input logic [15:0] bg);
    if (!c.vld) return 16'h0000;
`ifdef VGA_SPRITE_TRANSPARENT_EN
    if (c.spr && (q != KEY_COLOR)) return q;
`else
    if (c.spr) return q;
`endif
    return bg;
  endfunction

`ifndef VGA_SPRITE_TRANSPARENT_EN
  logic unused_key;
  assign unused_key = ^KEY_COLOR;
`endif

  // ---- S0: raster counters, position latch, sprite address ----
  logic [CNT_W-1:0]  h_cnt_p0, v_cnt_p0, px, py;
  logic [ADDR_W-1:0] addr_p0;
  logic [CNT_W:0]    px_end, py_end;
  logic              h_last, v_last, frame_end, in_spr_p0;
  ctl_t              ctl_p0;

  assign h_last    = (h_cnt_p0 == CNT_W'(H_TOTAL - 1));
  assign v_last    = (v_cnt_p0 == CNT_W'(V_TOTAL - 1));
  assign frame_end = h_last && v_last;
  assign px_end    = {1'b0, px} + (CNT_W+1)'(SPR_W);
  assign py_end    = {1'b0, py} + (CNT_W+1)'(SPR_H);
  assign in_spr_p0 = (h_cnt_p0 >= px) && ({1'b0, h_cnt_p0} < px_end) &&
                     (v_cnt_p0 >= py) && ({1'b0, v_cnt_p0} < py_end);

  assign ctl_p0.hs  = (h_cnt_p0 >= CNT_W'(HS_BEG)) && (h_cnt_p0 < CNT_W'(HS_END));
  assign ctl_p0.vs  = (v_cnt_p0 >= CNT_W'(VS_BEG)) && (v_cnt_p0 < CNT_W'(VS_END));
  assign ctl_p0.vld = (h_cnt_p0 < CNT_W'(H_ACTIVE)) && (v_cnt_p0 < CNT_W'(V_ACTIVE));
  assign ctl_p0.spr = in_spr_p0;
  assign ctl_p0.fs  = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
  assign rom_addr   = addr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      px       <= '0;
      py       <= '0;
      addr_p0  <= '0;
    end else begin
      h_cnt_p0 <= h_last ? '0 : h_cnt_p0 + CNT_W'(1);
      if (h_last) v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + CNT_W'(1);
      if (frame_end) begin
        px      <= clamp_pos(spr_x, PX_MAX);
        py      <= clamp_pos(spr_y, PY_MAX);
        addr_p0 <= '0;
      end else if (in_spr_p0) begin
        // Clamped positions guarantee this wrap lands on the last sprite pixel.
        addr_p0 <= (addr_p0 == ADDR_W'(SPR_N - 1)) ? '0 : addr_p0 + ADDR_W'(1);
      end
    end
  end

  // ---- S1..S(ROM_LAT): control delayed to line up with rom_q ----
  ctl_t ctl_p [ROM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) ctl_p[i] <= '0;
    end else begin
      ctl_p[0] <= ctl_p0;
      for (int i = 1; i < ROM_LAT; i++) ctl_p[i] <= ctl_p[i-1];
    end
  end

  // ---- S(ROM_LAT+1): pixel select and output registers ----
  logic [15:0] rgb_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      hsync       <= ctl_p[ROM_LAT-1].hs ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= ctl_p[ROM_LAT-1].vs ? SYNC_ACT : ~SYNC_ACT;
      de          <= ctl_p[ROM_LAT-1].vld;
      frame_start <= ctl_p[ROM_LAT-1].fs;
      rgb_out     <= pix_sel(ctl_p[ROM_LAT-1], rom_q, bg_color);
    end
  end

  assign vga_r = rgb_out[15:11];
  assign vga_g = rgb_out[10:5];
  assign vga_b = rgb_out[4:0];

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Randomized scoreboard bench for vga_sprite_ctrl on a reduced raster, with a
// pixel-level reference model (frame position arithmetic, ROM lookup by index).
module tb_vga_sprite_ctrl;

  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int SYNC_POL = 0;
  localparam int SPR_W = 8, SPR_H = 6;
  localparam int ROM_LAT = 2, ADDR_W = 6, CNT_W = 11;
  localparam logic [15:0] KEY = 16'hF81F;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = HT * VT;
  localparam int L = ROM_LAT + 1;
  localparam int N = SPR_W * SPR_H;
  localparam int NFRAMES = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [CNT_W-1:0]  spr_x, spr_y;
  logic [15:0]       bg_color;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic              hsync, vsync, de, frame_start;
  logic [4:0]        vga_r, vga_b;
  logic [5:0]        vga_g;

  vga_sprite_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL), .SPR_W(SPR_W), .SPR_H(SPR_H), .ROM_LAT(ROM_LAT),
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .KEY_COLOR(KEY)
  ) dut (
    .clk(clk), .rst(rst), .spr_x(spr_x), .spr_y(spr_y), .bg_color(bg_color),
    .rom_addr(rom_addr), .rom_q(rom_q), .hsync(hsync), .vsync(vsync), .de(de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with ROM_LAT cycles of read latency.
  logic [15:0] rom [2**ADDR_W];
  logic [15:0] rq  [ROM_LAT];
  always @(posedge clk) begin
    rq[0] <= rom[rom_addr];
    for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_q = rq[ROM_LAT-1];

  typedef struct {
    bit          care;
    bit          hs, vs, de, fs;
    logic [15:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t idle_exp();
    exp_t e;
    e.care = 1; e.hs = (SYNC_POL == 0); e.vs = (SYNC_POL == 0);
    e.de = 0; e.fs = 0; e.rgb = 16'h0000;
    return e;
  endfunction

  // Reference model: pixel (x,y) derived from cycles since reset release.
  int t = -1;
  int mpx = 0, mpy = 0;
  always @(posedge clk) begin
    exp_t e;
    int x, y, idx, a, c;
    logic [15:0] v;
    #2;
    if (rst) begin
      if (exp_q.size() == 0) begin
        e = idle_exp(); e.care = 0; exp_q.push_back(e);
      end else begin
        exp_q = exp_q[0:0];
      end
      for (int i = 0; i < L; i++) exp_q.push_back(idle_exp());
      addr_q.push_back(-1);
      t = -1; mpx = 0; mpy = 0;
    end else begin
      t++;
      x = t % HT;
      y = (t / HT) % VT;
      e.care = 1;
      e.hs = ((x >= H_ACTIVE + H_FP) && (x < H_ACTIVE + H_FP + H_SYNC)) ? (SYNC_POL != 0) : (SYNC_POL == 0);
      e.vs = ((y >= V_ACTIVE + V_FP) && (y < V_ACTIVE + V_FP + V_SYNC)) ? (SYNC_POL != 0) : (SYNC_POL == 0);
      e.de = (x < H_ACTIVE) && (y < V_ACTIVE);
      e.fs = (x == 0) && (y == 0);
      e.rgb = 16'h0000;
      if (e.de) begin
        e.rgb = bg_color;
        if (x >= mpx && x < mpx + SPR_W && y >= mpy && y < mpy + SPR_H) begin
          idx = (y - mpy) * SPR_W + (x - mpx);
          v = rom[idx];
`ifdef VGA_SPRITE_TRANSPARENT_EN
          if (v != KEY) e.rgb = v;
`else
          e.rgb = v;
`endif
        end
      end
      exp_q.push_back(e);
      // Address = number of sprite pixels already reached this frame, modulo N.
      a = 0;
      if (y >= mpy && y < mpy + SPR_H) begin
        c = (y - mpy) * SPR_W;
        if (x >= mpx + SPR_W) c += SPR_W;
        else if (x >= mpx) c += x - mpx;
        a = c % N;
      end
      addr_q.push_back(a);
      if (x == HT - 1 && y == VT - 1) begin
        mpx = (int'(spr_x) > H_ACTIVE - SPR_W) ? H_ACTIVE - SPR_W : int'(spr_x);
        mpy = (int'(spr_y) > V_ACTIVE - SPR_H) ? V_ACTIVE - SPR_H : int'(spr_y);
      end
    end
  end

  // Monitor: one expected output per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int a;
    logic [15:0] rgb;
    rgb = {vga_r, vga_g, vga_b};
    if (exp_q.size() == 0 || addr_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_underflow at %0t: exp_q=%0d addr_q=%0d entries, required nonzero", $time, exp_q.size(), addr_q.size());
    end else begin
      e = exp_q.pop_front();
      a = addr_q.pop_front();
      if (e.care) begin
        n_vec++;
        if (hsync !== e.hs || vsync !== e.vs || de !== e.de || frame_start !== e.fs || rgb !== e.rgb) begin
          n_err++;
          $display("FAIL pixel_out at %0t t=%0d: got hs=%b vs=%b de=%b fs=%b rgb=%h, expected hs=%b vs=%b de=%b fs=%b rgb=%h",
                   $time, t, hsync, vsync, de, frame_start, rgb, e.hs, e.vs, e.de, e.fs, e.rgb);
        end
      end
      if (a >= 0) begin
        n_vec++;
        if (rom_addr !== ADDR_W'(a)) begin
          n_err++;
          $display("FAIL rom_addr at %0t t=%0d: got %0d, expected %0d", $time, t, rom_addr, a);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void pick_pos(input int k);
    case (k % 4)
      0: begin spr_x = CNT_W'($urandom_range(0, H_ACTIVE - SPR_W)); spr_y = CNT_W'($urandom_range(0, V_ACTIVE - SPR_H)); end
      1: begin spr_x = CNT_W'($urandom_range(H_ACTIVE - SPR_W, 2047)); spr_y = CNT_W'($urandom_range(V_ACTIVE - SPR_H, 2047)); end
      2: begin spr_x = CNT_W'(H_ACTIVE - SPR_W); spr_y = CNT_W'(V_ACTIVE - SPR_H); end
      default: begin spr_x = CNT_W'($urandom_range(0, 3)); spr_y = '0; end
    endcase
  endfunction

  initial begin
    int fc, frame_no, chg_at, pos, did_rst;
    for (int i = 0; i < 2**ADDR_W; i++) rom[i] = 16'($urandom);
    rom[5] = KEY;
    rst = 1'b1; spr_x = 11'd20; spr_y = 11'd10; bg_color = 16'h001F;
    repeat (3) step();
    rst = 1'b0;
    fc = 0; frame_no = 0; did_rst = 0;
    chg_at = $urandom_range(0, FRAME - 1);
    for (int c = 0; c < NFRAMES * FRAME; c++) begin
      pos = fc % FRAME;
      if (pos == 0 && fc != 0) begin
        frame_no++;
        chg_at = (frame_no % 3 == 0) ? FRAME - 1 : $urandom_range(0, FRAME - 1);
      end
      if (pos == chg_at) pick_pos(frame_no);
      if (pos == (V_ACTIVE + 1) * HT) bg_color = 16'($urandom);
      if (!did_rst && frame_no == 6 && pos == 20 * HT + 10) begin
        did_rst = 1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        fc = 0;
        pos = 0;
      end
      step();
      fc++;
    end
    repeat (L + 2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
